// File: rtl/decoder_pkg.sv
`default_nettype none
// decoder_pkg: RV32I major opcodes and immediate-format codes shared by the decode stage.
package decoder_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } fmt_t;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_imm_gen.sv
`default_nettype none
// imm_gen: combinational RV32I immediate assembly and format classification.
module imm_gen
  import decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_sign;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];
  assign w_sign   = instruction[31];

  always_comb begin
    imm     = '0;
    fmt     = FMT_ILLEGAL;
    illegal = 1'b0;
    case (w_opcode)
      OP_IMM: begin
        fmt = FMT_I;
        // Shift-immediates carry funct7 in [31:25]; only the shamt is the immediate.
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          imm = {27'd0, instruction[24:20]};
        end else begin
          imm = {{20{w_sign}}, instruction[31:20]};
        end
      end
      LOAD, JALR, SYSTEM, MISC_MEM: begin
        fmt = FMT_I;
        imm = {{20{w_sign}}, instruction[31:20]};
      end
      STORE: begin
        fmt = FMT_S;
        imm = {{20{w_sign}}, instruction[31:25], instruction[11:7]};
      end
      BRANCH: begin
        fmt = FMT_B;
        imm = {{19{w_sign}}, instruction[31], instruction[7],
               instruction[30:25], instruction[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt = FMT_U;
        imm = {instruction[31:12], 12'd0};
      end
      JAL: begin
        fmt = FMT_J;
        imm = {{11{w_sign}}, instruction[31], instruction[19:12],
               instruction[20], instruction[30:21], 1'b0};
      end
      OP: begin
        fmt = FMT_R;
      end
      default: begin
        fmt     = FMT_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule : imm_gen
`default_nettype wire

// File: rtl/decoder.sv
`default_nettype none
// decoder: RV32I decode stage; raw field slicing plus immediate, registered with one cycle of latency.
module decoder
  import decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic            instr_valid,
  output logic            dec_valid,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [XLEN-1:0] w_imm;
  fmt_t            w_fmt;
  logic            w_illegal;

  logic            dec_valid_d, dec_valid_q;
  logic [6:0]      opcode_d, opcode_q;
  logic [4:0]      rd_d, rd_q;
  logic [2:0]      funct3_d, funct3_q;
  logic [4:0]      rs1_d, rs1_q;
  logic [4:0]      rs2_d, rs2_q;
  logic [6:0]      funct7_d, funct7_q;
  logic [XLEN-1:0] imm_d, imm_q;
  fmt_t            fmt_d, fmt_q;
  logic            illegal_d, illegal_q;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction (instruction),
    .imm         (w_imm),
    .fmt         (w_fmt),
    .illegal     (w_illegal)
  );

  // Idle cycles drop dec_valid but keep the last decode visible.
  always_comb begin
    dec_valid_d = instr_valid;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    funct3_d    = funct3_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    funct7_d    = funct7_q;
    imm_d       = imm_q;
    fmt_d       = fmt_q;
    illegal_d   = illegal_q;
    if (instr_valid) begin
      opcode_d  = instruction[6:0];
      rd_d      = instruction[11:7];
      funct3_d  = instruction[14:12];
      rs1_d     = instruction[19:15];
      rs2_d     = instruction[24:20];
      funct7_d  = instruction[31:25];
      imm_d     = w_imm;
      fmt_d     = w_fmt;
      illegal_d = w_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct7_q    <= '0;
      imm_q       <= '0;
      fmt_q       <= FMT_R;
      illegal_q   <= 1'b0;
    end else begin
      dec_valid_q <= dec_valid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      funct3_q    <= funct3_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      funct7_q    <= funct7_d;
      imm_q       <= imm_d;
      fmt_q       <= fmt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign dec_valid = dec_valid_q;
  assign opcode    = opcode_q;
  assign rd        = rd_q;
  assign funct3    = funct3_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign funct7    = funct7_q;
  assign imm       = imm_q;
  assign fmt       = fmt_q;
  assign illegal   = illegal_q;

endmodule : decoder
`default_nettype wire

// File: tb/tb_decoder.sv
`default_nettype none
// tb_decoder: directed vector bench for the RV32I decode stage.
module tb_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        dec_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  decoder #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .dec_valid   (dec_valid),
    .opcode      (opcode),
    .rd          (rd),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct7      (funct7),
    .imm         (imm),
    .fmt         (fmt),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input vec_t v, input logic exp_valid);
    chk({v.name, " dec_valid"}, {31'd0, dec_valid}, {31'd0, exp_valid});
    chk({v.name, " opcode"},    {25'd0, opcode},    {25'd0, v.opcode});
    chk({v.name, " rd"},        {27'd0, rd},        {27'd0, v.rd});
    chk({v.name, " funct3"},    {29'd0, funct3},    {29'd0, v.funct3});
    chk({v.name, " rs1"},       {27'd0, rs1},       {27'd0, v.rs1});
    chk({v.name, " rs2"},       {27'd0, rs2},       {27'd0, v.rs2});
    chk({v.name, " funct7"},    {25'd0, funct7},    {25'd0, v.funct7});
    chk({v.name, " imm"},       imm,                v.imm);
    chk({v.name, " fmt"},       {29'd0, fmt},       {29'd0, v.fmt});
    chk({v.name, " illegal"},   {31'd0, illegal},   {31'd0, v.illegal});
  endtask

  task automatic chk_zero(input string tag);
    vec_t z;
    z = '{name: tag, instr: 32'd0, opcode: 7'd0, rd: 5'd0, funct3: 3'd0, rs1: 5'd0,
          rs2: 5'd0, funct7: 7'd0, imm: 32'd0, fmt: 3'd0, illegal: 1'b0};
    chk_vec(z, 1'b0);
  endtask

  initial begin
    //           name      instr          op      rd     f3    rs1    rs2    f7     imm            fmt  ill
    vecs[0]  = '{"addi",   32'h00410093, 7'h13, 5'd1,  3'd0, 5'd2,  5'd4,  7'h00, 32'd4,         3'd1, 1'b0};
    vecs[1]  = '{"srli",   32'h00415093, 7'h13, 5'd1,  3'd5, 5'd2,  5'd4,  7'h00, 32'd4,         3'd1, 1'b0};
    vecs[2]  = '{"srai",   32'h40415093, 7'h13, 5'd1,  3'd5, 5'd2,  5'd4,  7'h20, 32'd4,         3'd1, 1'b0};
    vecs[3]  = '{"slli",   32'h00209093, 7'h13, 5'd1,  3'd1, 5'd1,  5'd2,  7'h00, 32'd2,         3'd1, 1'b0};
    vecs[4]  = '{"addi-1", 32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0,  5'h1F, 7'h7F, 32'hFFFFFFFF,  3'd1, 1'b0};
    vecs[5]  = '{"sw",     32'hFE512E23, 7'h23, 5'h1C, 3'd2, 5'd2,  5'd5,  7'h7F, 32'hFFFFFFFC,  3'd2, 1'b0};
    vecs[6]  = '{"beq",    32'hFE000CE3, 7'h63, 5'h19, 3'd0, 5'd0,  5'd0,  7'h7F, 32'hFFFFFFF8,  3'd3, 1'b0};
    vecs[7]  = '{"lui",    32'h123450B7, 7'h37, 5'd1,  3'd5, 5'd8,  5'd3,  7'h09, 32'h12345000,  3'd4, 1'b0};
    vecs[8]  = '{"jal",    32'h001000EF, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd1,  7'h00, 32'h00000800,  3'd5, 1'b0};
    vecs[9]  = '{"add",    32'h002081B3, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'd0,         3'd0, 1'b0};
    vecs[10] = '{"ecall",  32'h00000073, 7'h73, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'd0,         3'd1, 1'b0};
    vecs[11] = '{"ill10",  32'hFFF00010, 7'h10, 5'd0,  3'd0, 5'd0,  5'h1F, 7'h7F, 32'd0,         3'd7, 1'b1};
    vecs[12] = '{"ill7F",  32'h0000007F, 7'h7F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'd0,         3'd7, 1'b1};

    instruction = 32'd0;
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero("por");
    @(negedge clk);
    @(negedge clk);
    chk_zero("por_hold");
    rst_n = 1'b1;

    // Back-to-back stream: drive vector i while checking vector i-1.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i > 0) chk_vec(vecs[i-1], 1'b1);
      instruction = vecs[i].instr;
      instr_valid = 1'b1;
    end
    @(negedge clk);
    chk_vec(vecs[12], 1'b1);

    // Two idle cycles: dec_valid falls, decode of the illegal word holds.
    instr_valid = 1'b0;
    instruction = vecs[0].instr;
    @(negedge clk);
    chk_vec(vecs[12], 1'b0);
    @(negedge clk);
    chk_vec(vecs[12], 1'b0);

    // Mid-stream reset with instr_valid high.
    instruction = vecs[7].instr;
    instr_valid = 1'b1;
    @(negedge clk);
    chk_vec(vecs[7], 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk);
    chk_zero("rst_hold1");
    @(negedge clk);
    chk_zero("rst_hold2");
    instruction = vecs[5].instr;
    rst_n = 1'b1;
    #1 chk_zero("rst_release");
    @(negedge clk);
    chk_vec(vecs[5], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decoder
`default_nettype wire
